rv_imm_enc: RTL
===============

# rv_imm_enc

Pipelined RISC-V RV64I instruction encoder: the inverse of the core's immediate generator. It takes decoded fields (format, opcode, registers, funct fields) plus a 64-bit immediate and scatters the immediate into the I/S/B/U/J/shift bit positions to emit a 32-bit instruction word. It also flags any immediate the format cannot represent. It sits in the self-test/boot instruction generator path and feeds the instruction memory write port through a valid/ready stream.

## Interface
- `ERR_CNT_W`, default 16: width of the saturating error counter.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_n_i`  in  1  reset; asynchronous, active-low.
- `in_valid_i`  in  1  input field set valid.
- `in_ready_o`  out  1  encoder can accept this cycle.
- `fmt_i`  in  3  format: 0=I, 1=I-shift, 2=S, 3=B, 4=U, 5=J; 6 and 7 are reserved.
- `opcode_i`  in  7  placed at instr[6:0].
- `rd_i`, `rs1_i`, `rs2_i`  in  5 each  register fields.
- `funct3_i`  in  3  funct3 field.
- `funct7_i`  in  7  funct7 field; for I-shift, bits [6:1] are used.
- `imm_i`  in  64  immediate value (two's complement).
- `out_valid_o`  out  1  encoded word valid.
- `out_ready_i`  in  1  downstream accepts.
- `instr_o`  out  32  encoded instruction.
- `imm_err_o`  out  1  sideband with `instr_o`: immediate not representable, or `fmt_i` reserved.
- `err_clr_i`  in  1  synchronous clear of `err_cnt_o`.
- `err_cnt_o`  out  `ERR_CNT_W`  count of errored words delivered; saturates.

## Operation
- Field placement:
  - Common fields: opcode → [6:0]. rd → [11:7] for I, I-shift, U and J. funct3 → [14:12] for I, I-shift, S and B. rs1 → [19:15] for I, I-shift, S and B. rs2 → [24:20] for S and B.
  - I: [31:20] = imm[11:0].
  - I-shift: [31:26] = funct7[6:1], [25:20] = imm[5:0].
  - S: [31:25] = imm[11:5], [11:7] = imm[4:0].
  - B: [31] = imm[12], [30:25] = imm[10:5], [11:8] = imm[4:1], [7] = imm[11].
  - U: [31:12] = imm[31:12].
  - J: [31] = imm[20], [30:21] = imm[10:1], [20] = imm[11], [19:12] = imm[19:12].
- Range checks (error if violated):
  - I and S: imm[63:11] all equal.
  - I-shift: imm[63:6] == 0.
  - B: imm[0] == 0 and imm[63:12] all equal.
  - U: imm[11:0] == 0 and imm[63:31] all equal.
  - J: imm[0] == 0 and imm[63:20] all equal.
- On a range error the word is still encoded from the truncated bits, with `imm_err_o` = 1.
- Reserved fmt: `instr_o` = 32'h0000_0013 (NOP), `imm_err_o` = 1.
- Round-trip property: for any error-free word, feeding `instr_o` to the core immediate generator returns `imm_i`. For I-shift it returns the zero-extended shift amount.
- Pipeline:
  - Stage 1 (S1) registers the fields and computes the range check.
  - Stage 2 (S2) is the output register holding `instr_o` / `imm_err_o` / `out_valid_o`.
  - S2 loads when `!out_valid_o || out_ready_i`. S1 advances under the same condition.
  - `in_ready_o` = `!s1_valid || (!out_valid_o || out_ready_i)`, combinational from state and `out_ready_i`.
- Error counter:
  - Increments by 1 on every output handshake with `imm_err_o` = 1; holds at all-ones.
  - `err_clr_i` zeroes it. If a clear coincides with an errored handshake, the result is 1.

## Timing
- Reset values: `out_valid_o` = 0, `instr_o` = 0, `imm_err_o` = 0, `err_cnt_o` = 0, internal S1 valid = 0. `in_ready_o` reads 1 during and after reset.
- Latency: input handshake at cycle N gives `out_valid_o` at N+2 when unstalled.
- Throughput: 1 word per cycle with `out_ready_i` held high.
- Stall: while `out_valid_o && !out_ready_i`, `instr_o` and `imm_err_o` are held stable. Up to 2 words are buffered (S1 + S2), then `in_ready_o` = 0.
- Ordering: words leave strictly in acceptance order; none is dropped or duplicated.
- Simultaneous accept and output handshake in one cycle is legal and sustains full rate.
- Reset asserted mid-stream: all in-flight words are discarded asynchronously and outputs return to reset values immediately.

## Test plan
- ADDI, I-format: fmt=0, opcode=0x13, rd=1, rs1=0, f3=0, imm=-1 → `instr_o` = 0xFFF00093, err=0, 2 cycles after accept.
- BEQ and JAL: fmt=3, opcode=0x63, rs1=1, rs2=2, imm=8 → 0x00208463. fmt=5, opcode=0x6F, rd=1, imm=0x800 → 0x001000EF.
- LUI and SLLI: fmt=4, opcode=0x37, rd=1, imm=0x12345000 → 0x123450B7. fmt=1, opcode=0x13, rd=1, rs1=1, f3=1, funct7=0, imm=63 → 0x03F09093.
- Errors:
  - fmt=0, imm=2048 → err=1.
  - fmt=3, imm=3 → err=1.
  - fmt=1, imm=64 → err=1.
  - fmt=7 → 0x00000013 with err=1.
  - After all four are delivered, `err_cnt_o` = 4. Pulse `err_clr_i` → 0.
- Backpressure: hold `out_ready_i`=0 and drive 3 valid inputs back-to-back → `in_ready_o` drops after 2 accepts, `instr_o` stays stable. Release → all 3 words delivered in order.
- Reset mid-stream: assert `rst_n_i` low with 2 words in flight → `out_valid_o` = 0 and `instr_o` = 0 at once. After release, no stale word appears and the next input emerges at +2 cycles.

Source files
------------

// File: rtl/rv_imm_enc.sv
// Pipelined RV64I instruction encoder: scatters a 64-bit immediate plus decoded fields
// into a 32-bit instruction word, flagging immediates the format cannot represent.
module rv_imm_enc #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [2:0]               fmt_i,
    input  logic [6:0]               opcode_i,
    input  logic [4:0]               rd_i,
    input  logic [4:0]               rs1_i,
    input  logic [4:0]               rs2_i,
    input  logic [2:0]               funct3_i,
    input  logic [6:0]               funct7_i,
    input  logic signed [63:0]       imm_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [31:0]              instr_o,
    output logic                     imm_err_o,
    input  logic                     err_clr_i,
    output logic [ERR_CNT_W-1:0]     err_cnt_o
);

    localparam logic [2:0] FMT_I  = 3'd0;
    localparam logic [2:0] FMT_SH = 3'd1;
    localparam logic [2:0] FMT_S  = 3'd2;
    localparam logic [2:0] FMT_B  = 3'd3;
    localparam logic [2:0] FMT_U  = 3'd4;
    localparam logic [2:0] FMT_J  = 3'd5;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // True when v is the sign extension of its low 'bits' bits.
    function automatic logic fits_signed(input logic signed [63:0] v, input int unsigned bits);
        logic signed [63:0] s;
        s = (v <<< (64 - bits)) >>> (64 - bits);
        return s == v;
    endfunction

    function automatic logic range_err(input logic [2:0] fmt, input logic signed [63:0] imm);
        logic e;
        case (fmt)
            FMT_I, FMT_S: e = !fits_signed(imm, 12);
            FMT_SH:       e = (imm[63:6] != '0);
            FMT_B:        e = imm[0] || !fits_signed(imm, 13);
            FMT_U:        e = (imm[11:0] != '0) || !fits_signed(imm, 32);
            FMT_J:        e = imm[0] || !fits_signed(imm, 21);
            default:      e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] encode(
        input logic [2:0]  fmt,
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        logic [31:0] w;
        case (fmt)
            FMT_I:   w = {imm[11:0], rs1, f3, rd, op};
            FMT_SH:  w = {f7[6:1], imm[5:0], rs1, f3, rd, op};
            FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_U:   w = {imm[31:12], rd, op};
            FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: w = NOP;
        endcase
        return w;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
        return (&c) ? c : c + ERR_CNT_W'(1);
    endfunction

    logic        adv;
    logic        s1_vld_q;
    logic        out_vld_q;
    logic [31:0] instr_q;
    logic        err_q;
    logic [31:0] instr_d;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [ERR_CNT_W-1:0] err_cnt_d;

    logic [2:0]  fmt_p1_q;
    logic [6:0]  op_p1_q;
    logic [4:0]  rd_p1_q;
    logic [4:0]  rs1_p1_q;
    logic [4:0]  rs2_p1_q;
    logic [2:0]  f3_p1_q;
    logic [6:0]  f7_p1_q;
    logic [31:0] imm_p1_q;
    logic        err_p1_q;

    // Both stages move together whenever the output register is free or draining.
    assign adv        = !out_vld_q || out_ready_i;
    assign in_ready_o = !s1_vld_q || adv;

    // ---- S1: field capture and range check ----
    always_ff @(posedge clk_i) begin
        if (in_ready_o && in_valid_i) begin
            fmt_p1_q <= fmt_i;
            op_p1_q  <= opcode_i;
            rd_p1_q  <= rd_i;
            rs1_p1_q <= rs1_i;
            rs2_p1_q <= rs2_i;
            f3_p1_q  <= funct3_i;
            f7_p1_q  <= funct7_i;
            imm_p1_q <= imm_i[31:0];
            err_p1_q <= range_err(fmt_i, imm_i);
        end
    end

    // ---- S2: bit scatter into the output register ----
    always_comb begin
        instr_d = encode(fmt_p1_q, op_p1_q, rd_p1_q, rs1_p1_q, rs2_p1_q,
                         f3_p1_q, f7_p1_q, imm_p1_q);
    end

    // A clear that lands on an errored handshake still counts that word.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (out_vld_q && out_ready_i && err_q) begin
            err_cnt_d = err_clr_i ? ERR_CNT_W'(1) : sat_inc(err_cnt_q);
        end else if (err_clr_i) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_vld_q  <= 1'b0;
            out_vld_q <= 1'b0;
            instr_q   <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            if (in_ready_o) begin
                s1_vld_q <= in_valid_i;
            end
            if (adv) begin
                out_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    instr_q <= instr_d;
                    err_q   <= err_p1_q;
                end
            end
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid_o = out_vld_q;
    assign instr_o     = instr_q;
    assign imm_err_o   = err_q;
    assign err_cnt_o   = err_cnt_q;

endmodule
